fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch (IF) stage of the five-stage MIPS pipeline. Holds the program counter, a word-addressed instruction memory loaded by the debug unit, a PC+1 adder and the next-PC source multiplexer. It feeds the current instruction and the sequential next address to the IF/ID register, and takes redirect targets from the decode and execute stages.

## Interface
Parameters:
- NB_INST, 32, instruction width in bits.
- NB_DATA, 32, address/PC width in bits (codebase ADDRWIDTH).
- MEM_SIZE, 128, instruction memory depth in words (codebase N_ELEMENTS); power of two.

Ports:
- i_clk  in  1  single clock; all state updates on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_enable  in  1  PC update enable; the pipeline drives it as pc_write AND pipeline enable (stall when low).
- i_debug_unit  in  1  debug unit owns the instruction memory.
- i_Mem_WEn  in  1  instruction memory write enable.
- i_Mem_REn  in  1  instruction memory read enable.
- i_Mem_Data  in  NB_INST  word to write.
- i_wr_addr  in  NB_DATA  word address to write.
- i_PCsrc  in  NB_DATA  next-PC select; only bits [1:0] are decoded.
- i_addr_register  in  NB_DATA  jump-register target (JR/JALR).
- i_addr_branch  in  NB_DATA  branch target.
- i_addr_jump  in  NB_DATA  J/JAL target.
- i_jump_or_branch  in  1  control transfer taken this cycle; squash fetched instruction.
- o_instruction  out  NB_INST  instruction at PC.
- o_PCAddr  out  NB_DATA  PC + 1.

## Operation
- Memory: MEM_SIZE words of NB_INST bits, word-addressed; index = low log2(MEM_SIZE) bits of the address (out-of-range addresses wrap).
- Write: on rising edge when i_debug_unit=1 and i_Mem_WEn=1, mem[i_wr_addr] <= i_Mem_Data. No write otherwise.
- Read: combinational. o_instruction = mem[PC] when i_Mem_REn=1 and i_jump_or_branch=0; otherwise 32'h0 (NOP).
- o_PCAddr = PC + 1, combinational, modulo 2^NB_DATA.
- Next PC by i_PCsrc[1:0]: 0 → PC+1; 1 → i_addr_branch; 2 → i_addr_jump; 3 → i_addr_register.
- PC register: on rising edge, if i_reset → 0; else if i_enable=1 and i_debug_unit=0 → next PC; else hold.
- Memory contents not affected by reset; undefined until loaded (simulation may initialise to 0).

## Timing
- Reset: PC=0 on the first edge with i_reset=1; then o_PCAddr=1 and o_instruction=mem[0] (if REn=1).
- Fetch latency: zero cycles from PC to o_instruction (combinational read); PC advances one word per enabled edge.
- Redirect: i_PCsrc/target sampled at the edge; the new PC's instruction appears in the same cycle after that edge.
- Stall: i_enable=0 freezes PC; outputs remain stable unless memory is written at PC or i_jump_or_branch/REn change.
- Simultaneous write to address PC and read: o_instruction shows old word until the edge, new word after.
- Reset has priority over enable and redirect; reset mid-debug-load does not block the memory write in that cycle.
- Debug mode (i_debug_unit=1) holds PC regardless of i_enable.

## Test plan
- Load: debug=1, WEn=1, write 11 words to addr 0..10 (addr0 = 32'h3C01000A, addr4 = 32'h10640007, addr10 = 32'hFC000000); then debug=0, REn=1, reset → o_instruction=32'h3C01000A, o_PCAddr=1.
- Sequential: enable=1, PCsrc=0 for 4 edges → PC 1,2,3,4; o_instruction at PC=4 = 32'h10640007, o_PCAddr=5.
- Stall: enable=0 for 3 edges → PC and outputs unchanged; re-enable → PC resumes +1.
- Redirect: PCsrc=1, branch=8 → PC=8; PCsrc=2, jump=7 → PC=7; PCsrc=3, register=10 → PC=10, o_instruction=32'hFC000000.
- Squash/read gating: i_jump_or_branch=1 or REn=0 → o_instruction=0 while o_PCAddr still PC+1.
- Reset mid-run at PC=10 → PC=0, o_instruction=mem[0], memory contents preserved.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: program counter, debug-loaded instruction memory,
// PC+1 adder and next-PC source selection feeding the IF/ID register.
module fetch_stage #(
  parameter int NB_INST  = 32,
  parameter int NB_DATA  = 32,
  parameter int MEM_SIZE = 128
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_enable,
  input  logic               i_debug_unit,
  input  logic               i_Mem_WEn,
  input  logic               i_Mem_REn,
  input  logic [NB_INST-1:0] i_Mem_Data,
  input  logic [NB_DATA-1:0] i_wr_addr,
  input  logic [NB_DATA-1:0] i_PCsrc,
  input  logic [NB_DATA-1:0] i_addr_register,
  input  logic [NB_DATA-1:0] i_addr_branch,
  input  logic [NB_DATA-1:0] i_addr_jump,
  input  logic               i_jump_or_branch,
  output logic [NB_INST-1:0] o_instruction,
  output logic [NB_DATA-1:0] o_PCAddr
);

  localparam int NB_IDX = $clog2(MEM_SIZE);

  typedef enum logic [1:0] {
    SRC_SEQ      = 2'd0,
    SRC_BRANCH   = 2'd1,
    SRC_JUMP     = 2'd2,
    SRC_REGISTER = 2'd3
  } pc_src_t;

  logic [NB_INST-1:0] mem [MEM_SIZE];
  logic [NB_DATA-1:0] pc;
  logic [NB_DATA-1:0] pc_plus1;
  logic [NB_DATA-1:0] pc_next;
  logic [NB_IDX-1:0]  rd_idx;
  logic [NB_IDX-1:0]  wr_idx;
  pc_src_t            pc_src;
  logic               unused_bits;

  // Addresses wrap onto the memory: only the low index bits select a word.
  assign rd_idx   = pc[NB_IDX-1:0];
  assign wr_idx   = i_wr_addr[NB_IDX-1:0];
  assign pc_src   = pc_src_t'(i_PCsrc[1:0]);
  assign pc_plus1 = pc + NB_DATA'(1);

  assign unused_bits = ^{i_PCsrc[NB_DATA-1:2], i_wr_addr[NB_DATA-1:NB_IDX]};

  always_comb begin
    pc_next = pc_plus1;
    case (pc_src)
      SRC_SEQ:      pc_next = pc_plus1;
      SRC_BRANCH:   pc_next = i_addr_branch;
      SRC_JUMP:     pc_next = i_addr_jump;
      SRC_REGISTER: pc_next = i_addr_register;
      default:      pc_next = pc_plus1;
    endcase
  end

  // Memory is not reset; the debug unit load is honoured even during reset.
  always_ff @(posedge i_clk) begin
    if (i_debug_unit && i_Mem_WEn) begin
      mem[wr_idx] <= i_Mem_Data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pc <= '0;
    end else if (i_enable && !i_debug_unit) begin
      pc <= pc_next;
    end
  end

  // A taken control transfer squashes the fetched word into a NOP.
  always_comb begin
    o_instruction = '0;
    if (i_Mem_REn && !i_jump_or_branch) begin
      o_instruction = mem[rd_idx];
    end
  end

  assign o_PCAddr = pc_plus1;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, hand-written corner sequences,
// then randomized traffic checked against a word-array/PC reference model.
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        debug_unit;
  logic        mem_wen;
  logic        mem_ren;
  logic [31:0] mem_data;
  logic [31:0] wr_addr;
  logic [31:0] pcsrc;
  logic [31:0] addr_register;
  logic [31:0] addr_branch;
  logic [31:0] addr_jump;
  logic        jump_or_branch;
  logic [31:0] instruction;
  logic [31:0] pc_addr;

  int checks = 0;
  int errors = 0;

  // Reference model: plain array of words and an integer-style PC.
  logic [31:0] m_mem [128];
  logic [31:0] m_pc;

  logic [31:0] prog [11];

  typedef struct {
    string       name;
    bit          rst;
    bit          en;
    bit          dbg;
    bit          ren;
    bit          jb;
    logic [1:0]  sel;
    logic [31:0] br;
    logic [31:0] jp;
    logic [31:0] rg;
    logic [31:0] exp_instr;
    logic [31:0] exp_pcaddr;
  } vec_t;

  vec_t vecs [16];

  fetch_stage #(.NB_INST(32), .NB_DATA(32), .MEM_SIZE(128)) dut (
    .i_clk            (clk),
    .i_reset          (reset),
    .i_enable         (enable),
    .i_debug_unit     (debug_unit),
    .i_Mem_WEn        (mem_wen),
    .i_Mem_REn        (mem_ren),
    .i_Mem_Data       (mem_data),
    .i_wr_addr        (wr_addr),
    .i_PCsrc          (pcsrc),
    .i_addr_register  (addr_register),
    .i_addr_branch    (addr_branch),
    .i_addr_jump      (addr_jump),
    .i_jump_or_branch (jump_or_branch),
    .o_instruction    (instruction),
    .o_PCAddr         (pc_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, got, exp);
    end
  endtask

  task automatic idle_inputs();
    reset = 0; enable = 0; debug_unit = 0; mem_wen = 0; mem_ren = 1;
    mem_data = '0; wr_addr = '0; pcsrc = '0; jump_or_branch = 0;
    addr_register = '0; addr_branch = '0; addr_jump = '0;
  endtask

  // One clock edge; the model consumes the same inputs the DUT sampled.
  task automatic tick();
    @(posedge clk);
    if (debug_unit && mem_wen) m_mem[wr_addr % 128] = mem_data;
    if (reset) m_pc = 0;
    else if (enable && !debug_unit) begin
      if (pcsrc % 4 == 0)      m_pc = m_pc + 1;
      else if (pcsrc % 4 == 1) m_pc = addr_branch;
      else if (pcsrc % 4 == 2) m_pc = addr_jump;
      else                     m_pc = addr_register;
    end
    #1;
  endtask

  function automatic logic [31:0] model_instr();
    return (mem_ren && !jump_or_branch) ? m_mem[m_pc % 128] : 32'h0;
  endfunction

  task automatic load_word(input logic [31:0] addr, input logic [31:0] data);
    idle_inputs();
    debug_unit = 1; mem_wen = 1; wr_addr = addr; mem_data = data;
    tick();
  endtask

  initial begin
    prog[0] = 32'h3C01000A; prog[1] = 32'h3C020014; prog[2]  = 32'h00221820;
    prog[3] = 32'hAC030000; prog[4] = 32'h10640007; prog[5]  = 32'h8C040000;
    prog[6] = 32'h00000000; prog[7] = 32'h08000003; prog[8]  = 32'h20A50001;
    prog[9] = 32'h00853020; prog[10] = 32'hFC000000;
    for (int i = 0; i < 128; i++) m_mem[i] = '0;
    m_pc = '0;

    //        name        rst en dbg ren jb sel br  jp  rg   instr      pcaddr
    vecs[0]  = '{"reset",   1, 0, 0, 1, 0, 0,  0,  0,  0,  prog[0],  1};
    vecs[1]  = '{"seq1",    0, 1, 0, 1, 0, 0, 30, 31, 32, prog[1],  2};
    vecs[2]  = '{"seq2",    0, 1, 0, 1, 0, 0, 30, 31, 32, prog[2],  3};
    vecs[3]  = '{"seq3",    0, 1, 0, 1, 0, 0, 30, 31, 32, prog[3],  4};
    vecs[4]  = '{"seq4",    0, 1, 0, 1, 0, 0, 30, 31, 32, prog[4],  5};
    vecs[5]  = '{"stall1",  0, 0, 0, 1, 0, 1,  9,  9,  9, prog[4],  5};
    vecs[6]  = '{"stall2",  0, 0, 0, 1, 0, 2,  9,  9,  9, prog[4],  5};
    vecs[7]  = '{"stall3",  0, 0, 0, 1, 0, 3,  9,  9,  9, prog[4],  5};
    vecs[8]  = '{"resume",  0, 1, 0, 1, 0, 0,  9,  9,  9, prog[5],  6};
    vecs[9]  = '{"branch",  0, 1, 0, 1, 0, 1,  8,  3,  2, prog[8],  9};
    vecs[10] = '{"jump",    0, 1, 0, 1, 0, 2,  1,  7,  2, prog[7],  8};
    vecs[11] = '{"jreg",    0, 1, 0, 1, 0, 3,  1,  3, 10, prog[10], 11};
    vecs[12] = '{"squash",  0, 0, 0, 1, 1, 0,  0,  0,  0, 32'h0,    11};
    vecs[13] = '{"ren_off", 0, 0, 0, 0, 0, 0,  0,  0,  0, 32'h0,    11};
    vecs[14] = '{"dbg_hold",0, 1, 1, 1, 0, 0,  0,  0,  0, prog[10], 11};
    vecs[15] = '{"rst_prio",1, 1, 0, 1, 0, 2,  5,  7,  5, prog[0],  1};

    idle_inputs();
    reset = 1;
    tick();

    for (int i = 0; i < 11; i++) load_word(i, prog[i]);
    load_word(127, 32'h0BADF00D);

    for (int i = 0; i < 16; i++) begin
      idle_inputs();
      reset = vecs[i].rst; enable = vecs[i].en; debug_unit = vecs[i].dbg;
      mem_ren = vecs[i].ren; jump_or_branch = vecs[i].jb; pcsrc = {30'd0, vecs[i].sel};
      addr_branch = vecs[i].br; addr_jump = vecs[i].jp; addr_register = vecs[i].rg;
      tick();
      check({vecs[i].name, "_instr"}, instruction, vecs[i].exp_instr);
      check({vecs[i].name, "_pcaddr"}, pc_addr, vecs[i].exp_pcaddr);
    end

    // Write to the word at PC: old word until the edge, new word after.
    idle_inputs();
    debug_unit = 1; mem_wen = 1; wr_addr = 0; mem_data = 32'hDEADBEEF; enable = 1;
    #1;
    check("wr_at_pc_before", instruction, prog[0]);
    tick();
    check("wr_at_pc_after", instruction, 32'hDEADBEEF);
    check("wr_at_pc_pcaddr", pc_addr, 32'd1);
    // Out-of-range write address wraps onto word 0.
    wr_addr = 32'd128; mem_data = prog[0];
    tick();
    check("wr_wrap", instruction, prog[0]);

    // Reset while the debug unit is loading: PC clears and the write lands.
    idle_inputs();
    enable = 1; pcsrc = 3; addr_register = 10;
    tick();
    check("pre_rst_pcaddr", pc_addr, 32'd11);
    idle_inputs();
    reset = 1; debug_unit = 1; mem_wen = 1; wr_addr = 20; mem_data = 32'h12345678; enable = 1;
    tick();
    check("rst_load_pcaddr", pc_addr, 32'd1);
    check("rst_load_instr", instruction, prog[0]);
    idle_inputs();
    enable = 1; pcsrc = 1; addr_branch = 20;
    tick();
    check("rst_load_written", instruction, 32'h12345678);
    check("rst_load_br_pcaddr", pc_addr, 32'd21);

    // PC at the top of the address space: PC+1 wraps, read index wraps.
    idle_inputs();
    enable = 1; pcsrc = 3; addr_register = 32'hFFFFFFFF;
    tick();
    check("pc_max_pcaddr", pc_addr, 32'd0);
    check("pc_max_instr", instruction, 32'h0BADF00D);
    idle_inputs();
    enable = 1;
    tick();
    check("pc_wrap_pcaddr", pc_addr, 32'd1);
    check("pc_wrap_instr", instruction, prog[0]);

    // Randomized traffic against the model, over a fully loaded memory.
    for (int i = 0; i < 128; i++) load_word(i, $urandom);
    for (int n = 0; n < 400; n++) begin
      idle_inputs();
      reset          = ($urandom_range(0, 49) == 0);
      debug_unit     = ($urandom_range(0, 4) == 0);
      mem_wen        = $urandom_range(0, 1);
      wr_addr        = $urandom;
      mem_data       = $urandom;
      mem_ren        = ($urandom_range(0, 3) != 0);
      jump_or_branch = ($urandom_range(0, 4) == 0);
      enable         = ($urandom_range(0, 3) != 0);
      pcsrc          = $urandom;
      addr_branch    = $urandom;
      addr_jump      = $urandom;
      addr_register  = $urandom;
      tick();
      check("rand_instr", instruction, model_instr());
      check("rand_pcaddr", pc_addr, m_pc + 32'd1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
